wb_sram_ctrl: RTL and testbench

- Wishbone classic slave that adapts the management SoC Wishbone bus to a single-port synchronous 1024x32 SRAM macro with byte write enables.
- Sits directly downstream of the user-project Wishbone slave port and directly upstream of the SRAM macro.
- Decodes its address window, generates macro strobes, registers read data and generates wbs_ack_o.
- After reset, optionally sweeps the whole array to zero before accepting traffic.

---
 rtl/wb_sram_pkg.sv | 24 ++
 rtl/wb_sram_init_sweep.sv | 45 ++++
 rtl/wb_sram_ctrl.sv | 156 +++++++++++++++
 tb/tb_wb_sram_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_pkg.sv
// Shared types and helpers for the Wishbone-to-SRAM adapter.
package wb_sram_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    localparam int ADDR_W_DEFAULT = 10;
    localparam int WORDS          = 2 ** ADDR_W_DEFAULT;
    localparam int SEL_W          = 4;

    // Compare only the bits above the byte offset covered by the macro.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] base,
                                       input int          addr_w);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (addr_w + 2);
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/wb_sram_init_sweep.sv
// Address counter for the post-reset zero-fill of the SRAM array.
module wb_sram_init_sweep
    import wb_sram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] count_q, count_d;
    logic              last_q, last_d;
    logic              done_q, done_d;

    // Done trails the final sweep write by one cycle so it rises once IDLE is entered.
    always_comb begin
        count_d = count_q;
        last_d  = active_i && (count_q == '1);
        done_d  = done_q | last_q;
        if (active_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign addr_o = count_q;
    assign last_o = last_d;
    assign done_o = done_q;

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave fronting a 1024x32 single-port synchronous SRAM macro
// with byte write enables, plus an optional zero-fill sweep after reset.
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 10,
    parameter int          DATA_W    = 32,
    parameter int          INIT_ZERO = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [SEL_W-1:0]  wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic              ram_en_o,
    output logic [SEL_W-1:0]  ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic              init_done_o
);

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              en_q, en_d;
    logic [SEL_W-1:0]  we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;

    logic              req;
    logic              hit;
    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep_last;
    logic              sweep_done;

    assign req = wbs_cyc_i & wbs_stb_i;
    assign hit = req & in_window(wbs_adr_i, BASE_ADDR, ADDR_W);

    generate
        if (INIT_ZERO != 0) begin : g_sweep
            wb_sram_init_sweep #(.ADDR_W(ADDR_W)) u_sweep (
                .clk      (wb_clk_i),
                .rst_n    (wb_rst_n_i),
                .active_i (state_q == ST_INIT),
                .addr_o   (sweep_addr),
                .last_o   (sweep_last),
                .done_o   (sweep_done)
            );
        end else begin : g_no_sweep
            assign sweep_addr = '0;
            assign sweep_last = 1'b1;
            assign sweep_done = 1'b1;
        end
    endgenerate

    // IDLE ignores the bus while ack_q is high: the master still holds stb for the finished request.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        rd_ack_d = 1'b0;
        dat_d    = dat_q;
        en_d     = 1'b0;
        we_d     = '0;
        addr_d   = addr_q;
        din_d    = din_q;
        case (state_q)
            ST_INIT: begin
                en_d   = 1'b1;
                we_d   = '1;
                din_d  = '0;
                addr_d = sweep_addr;
                if (sweep_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req && !ack_q) begin
                    if (hit) begin
                        en_d   = 1'b1;
                        addr_d = wbs_adr_i[ADDR_W+1:2];
                        if (wbs_we_i) begin
                            we_d    = wbs_sel_i;
                            din_d   = wbs_dat_i;
                            state_d = ST_ACK;
                        end else begin
                            state_d = ST_RD;
                        end
                    end else begin
                        if (!wbs_we_i) begin
                            dat_d = '0;
                        end
                        state_d = ST_ACK;
                    end
                end
            end
            ST_RD: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_ack_d = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                // The macro's read data is on ram_dout_i during this cycle.
                ack_d = 1'b1;
                if (rd_ack_q) begin
                    dat_d = ram_dout_i;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
            ack_q    <= 1'b0;
            rd_ack_q <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            we_q     <= '0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rd_ack_q <= rd_ack_d;
            dat_q    <= dat_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign ram_en_o    = en_q;
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_din_o   = din_q;
    assign init_done_o = sweep_done;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Self-checking bench for wb_sram_ctrl with a behavioural SRAM macro and a
// shadow memory feeding a scoreboard of expected ack data.
module tb_wb_sram_ctrl;
    import wb_sram_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_din_o;
    logic [31:0] ram_dout;
    logic        init_done_o;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] shadow [WORDS];
    logic [31:0] macro_mem [WORDS];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    logic [31:0] merged;

    always #5 clk = ~clk;

    wb_sram_ctrl #(
        .BASE_ADDR (BASE),
        .ADDR_W    (10),
        .DATA_W    (32),
        .INIT_ZERO (1)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_din_o   (ram_din_o),
        .ram_dout_i  (ram_dout),
        .init_done_o (init_done_o)
    );

    // Synchronous single-port macro: byte-masked writes, read data valid the cycle after en.
    always @(posedge clk) begin
        if (ram_en_o) begin
            merged = macro_mem[ram_addr_o];
            for (int b = 0; b < 4; b++) begin
                if (ram_we_o[b]) merged[8*b +: 8] = ram_din_o[8*b +: 8];
            end
            macro_mem[ram_addr_o] <= merged;
            if (ram_we_o == 4'h0) ram_dout <= macro_mem[ram_addr_o];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
        tick();
        tick();
        for (int i = 0; i < WORDS; i++) shadow[i] = 32'h0;
        last_rd = 32'h0;
        exp_q.delete();
    endtask

    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] s,
                                 input logic [31:0] d, input int exp_lat, input string tag);
        logic        in_win;
        int          word;
        int          lat;
        logic        first_en, any_en;
        logic [3:0]  first_we;
        logic [9:0]  first_addr;
        logic [31:0] exp_dat, got;
        in_win = (a[31:12] == BASE[31:12]);
        word   = int'(a[11:2]);
        if (w) begin
            if (in_win) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) shadow[word][8*b +: 8] = d[8*b +: 8];
                end
            end
            exp_dat = last_rd;
        end else begin
            exp_dat = in_win ? shadow[word] : 32'h0;
        end
        exp_q.push_back(exp_dat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d;
        lat = 0; any_en = 1'b0; first_en = 1'b0; first_we = 4'h0; first_addr = 10'h0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (n == 1) begin
                first_en = ram_en_o; first_we = ram_we_o; first_addr = ram_addr_o;
            end
            any_en |= ram_en_o;
            if (wbs_ack_o) begin
                lat = n;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        got = exp_q.pop_front();
        checkOutput({tag, "_dat"}, wbs_dat_o, got);
        if (!w) last_rd = exp_dat;
        if (in_win) begin
            checkOutput({tag, "_en"}, {31'h0, first_en}, 32'h1);
            checkOutput({tag, "_addr"}, {22'h0, first_addr}, 32'(word));
            checkOutput({tag, "_we"}, {28'h0, first_we}, {28'h0, (w ? s : 4'h0)});
        end else begin
            checkOutput({tag, "_no_en"}, {31'h0, any_en}, 32'h0);
        end
        tick();
        checkOutput({tag, "_ack_once"}, {31'h0, wbs_ack_o}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          bad, done_edge, ack_edge, addr_at2;
        logic        ack_seen, early;
        logic [31:0] a, d, got;

        applyReset();
        checkOutput("rst_ack",  {31'h0, wbs_ack_o}, 32'h0);
        checkOutput("rst_dat",  wbs_dat_o, 32'h0);
        checkOutput("rst_en",   {31'h0, ram_en_o}, 32'h0);
        checkOutput("rst_we",   {28'h0, ram_we_o}, 32'h0);
        checkOutput("rst_addr", {22'h0, ram_addr_o}, 32'h0);
        checkOutput("rst_din",  ram_din_o, 32'h0);
        checkOutput("rst_done", {31'h0, init_done_o}, 32'h0);

        rst_n = 1'b1;
        bad = 0; done_edge = 0;
        for (int e = 1; e <= 1100; e++) begin
            tick();
            if (e <= WORDS) begin
                if (!(ram_en_o === 1'b1 && ram_we_o === 4'hF && ram_din_o === 32'h0 &&
                      ram_addr_o === 10'(e - 1))) bad++;
            end
            if (init_done_o === 1'b1 && done_edge == 0) begin
                done_edge = e;
                break;
            end
        end
        checkOutput("sweep_bad_cycles", 32'(bad), 32'h0);
        checkOutput("sweep_done_edge", 32'(done_edge), 32'd1025);

        applyStimulus(1'b0, 32'h3000_0FFC, 4'hF, 32'h0, 3, "rd_top_zero");
        applyStimulus(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 2, "wr_full");
        applyStimulus(1'b0, 32'h3000_0010, 4'hF, 32'h0, 3, "rd_full");
        applyStimulus(1'b1, 32'h3000_0010, 4'b0100, 32'h00AA_0000, 2, "wr_byte");
        applyStimulus(1'b0, 32'h3000_0010, 4'hF, 32'h0, 3, "rd_byte");
        checkOutput("byte_merge_value", wbs_dat_o, 32'hDEAA_BEEF);
        applyStimulus(1'b0, 32'h3000_1000, 4'hF, 32'h0, 2, "rd_oow");
        applyStimulus(1'b1, 32'h3000_0020, 4'h0, 32'h5555_5555, 2, "wr_sel0");
        applyStimulus(1'b0, 32'h3000_0020, 4'hF, 32'h0, 3, "rd_sel0");
        applyStimulus(1'b0, 32'h3000_0010, 4'hF, 32'h0, 3, "rd_before_abort");

        // Read abandoned while the controller waits on the macro.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0FFC; sel = 4'hF;
        tick();
        ack_seen = wbs_ack_o;
        cyc = 1'b0; stb = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            ack_seen |= wbs_ack_o;
        end
        checkOutput("abort_no_ack", {31'h0, ack_seen}, 32'h0);
        checkOutput("abort_dat_held", wbs_dat_o, last_rd);
        applyStimulus(1'b1, 32'h3000_0030, 4'hF, 32'hCAFE_F00D, 2, "wr_after_abort");
        applyStimulus(1'b0, 32'h3000_0030, 4'hF, 32'h0, 3, "rd_after_abort");

        for (int k = 0; k < 4; k++) begin
            a = BASE | {20'h0, 10'($urandom_range(0, WORDS - 1)), 2'b00};
            d = $urandom;
            applyStimulus(1'b1, a, 4'($urandom_range(1, 15)), d, 2, "wr_rand");
            applyStimulus(1'b0, a, 4'hF, 32'h0, 3, "rd_rand");
        end

        // Reset pulsed mid-sweep, then a write held across the whole restarted sweep.
        applyReset();
        rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            tick();
            if (ram_addr_o === 10'd500) break;
        end
        checkOutput("pre_pulse_addr", {22'h0, ram_addr_o}, 32'd500);
        rst_n = 1'b0;
        tick();
        checkOutput("pulse_addr", {22'h0, ram_addr_o}, 32'h0);
        checkOutput("pulse_en", {31'h0, ram_en_o}, 32'h0);
        checkOutput("pulse_done", {31'h0, init_done_o}, 32'h0);
        for (int i = 0; i < WORDS; i++) shadow[i] = 32'h0;
        last_rd = 32'h0;
        shadow[16] = 32'h1234_5678;
        exp_q.push_back(last_rd);
        rst_n = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0040; sel = 4'hF; dat = 32'h1234_5678;
        done_edge = 0; ack_edge = 0; addr_at2 = 0; early = 1'b0;
        for (int e = 1; e <= 1200; e++) begin
            tick();
            if (e == 2) addr_at2 = int'(ram_addr_o);
            if (init_done_o === 1'b1 && done_edge == 0) done_edge = e;
            if (wbs_ack_o === 1'b1) begin
                if (done_edge == 0) early = 1'b1;
                ack_edge = e;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        got = exp_q.pop_front();
        checkOutput("held_wr_dat", wbs_dat_o, got);
        checkOutput("restart_addr_edge2", 32'(addr_at2), 32'd1);
        checkOutput("restart_done_edge", 32'(done_edge), 32'd1025);
        checkOutput("held_ack_early", {31'h0, early}, 32'h0);
        checkOutput("held_ack_edge", 32'(ack_edge), 32'd1026);
        tick();
        checkOutput("held_ack_once", {31'h0, wbs_ack_o}, 32'h0);
        applyStimulus(1'b0, 32'h3000_0040, 4'hF, 32'h0, 3, "rd_held");
        applyStimulus(1'b0, 32'h3000_0010, 4'hF, 32'h0, 3, "rd_rezeroed");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
